// File: rtl/capture_pkg.sv
// Shared constants for the capture write scheduler: FSM encoding, AXI field
// values and the 4 KiB burst boundary.
package capture_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_AW     = 3'd1;
    localparam logic [2:0] ST_W      = 3'd2;
    localparam logic [2:0] ST_WAIT_B = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;
    localparam logic [2:0] AXI_PROT_DATA  = 3'b000;

    localparam int unsigned BOUNDARY_BYTES = 4096;
    localparam int unsigned BOUNDARY_LOG   = 12;

endpackage

// File: rtl/capture_wr_sched_if.sv
// Command, capture-stream, AXI write and status signals of the capture write
// scheduler; master is the scheduler side, slave the environment side.
interface capture_wr_sched_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 34
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]           cmd_len;

    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic [KEEP_WIDTH-1:0] s_axis_tkeep;
    logic                  s_axis_tvalid;
    logic                  s_axis_tlast;
    logic                  s_axis_tready;

    logic [5:0]            m_axi_awid;
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0]            m_axi_awlen;
    logic [2:0]            m_axi_awsize;
    logic [1:0]            m_axi_awburst;
    logic                  m_axi_awlock;
    logic [3:0]            m_axi_awcache;
    logic [2:0]            m_axi_awprot;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;

    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [KEEP_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_wlast;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;

    logic [5:0]            m_axi_bid;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    logic                  busy;
    logic                  done;
    logic                  err_resp;
    logic                  err_len;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        output cmd_ready,
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        output m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output busy, done, err_resp, err_len
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        input  cmd_ready,
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        input  m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  busy, done, err_resp, err_len
    );
endinterface

// File: rtl/capture_burst_calc.sv
// Next burst length: the smallest of beats remaining, the burst cap and the
// beats left before the current address crosses a 4 KiB boundary.
module capture_burst_calc
    import capture_pkg::*;
#(
    parameter int KEEP_WIDTH    = 64,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [BOUNDARY_LOG-1:0] addr_lo,
    input  logic [31:0]             beats_left,
    output logic [8:0]              burst_len
);
    localparam int BPB_LOG = $clog2(KEEP_WIDTH);

    logic [31:0] to_boundary;

    always_comb begin
        // addr_lo is beat aligned, so the shift is an exact division
        to_boundary = (32'(BOUNDARY_BYTES) - 32'(addr_lo)) >> BPB_LOG;
        burst_len   = 9'(MAX_BURST_LEN);
        if (to_boundary < 32'(burst_len))
            burst_len = to_boundary[8:0];
        if (beats_left < 32'(burst_len))
            burst_len = beats_left[8:0];
    end
endmodule

// File: rtl/capture_wr_sched.sv
// Capture write scheduler: splits a byte-length command into AXI INCR bursts and
// streams the capture FIFO straight onto the W channel.
module capture_wr_sched
    import capture_pkg::*;
#(
    parameter int DATA_WIDTH      = 512,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH      = 34,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic m_axi_aclk,
    input  logic m_axi_aresetn,
    capture_wr_sched_if.master bus
);
    localparam int BPB_LOG = $clog2(KEEP_WIDTH);
    localparam int OST_W   = $clog2(MAX_OUTSTANDING + 1);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           beats_left;
    logic [8:0]            burst_len;
    logic [8:0]            burst_q;
    logic [8:0]            beat_cnt;
    logic [OST_W-1:0]      outstanding;
    logic                  err_resp_q;
    logic                  err_len_q;

    logic [31:0] cmd_beats;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        last_of_cmd;
    logic        unused_bid;

    capture_burst_calc #(
        .KEEP_WIDTH    (KEEP_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_burst_calc (
        .addr_lo    (addr_q[BOUNDARY_LOG-1:0]),
        .beats_left (beats_left),
        .burst_len  (burst_len)
    );

    // Rounded-up beat count without the overflow of (len + BPB - 1)
    assign cmd_beats = (bus.cmd_len >> BPB_LOG) + 32'(|bus.cmd_len[BPB_LOG-1:0]);

    assign aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
    assign w_hs  = bus.m_axi_wvalid && bus.m_axi_wready;
    // Responses with nothing outstanding belong to bursts dropped by a reset
    assign b_hs  = bus.m_axi_bvalid && bus.m_axi_bready && (outstanding != '0);
    assign last_of_cmd = bus.m_axi_wlast && (beats_left == 32'd0);
    assign unused_bid  = ^bus.m_axi_bid;

    assign bus.cmd_ready     = (state == ST_IDLE);
    assign bus.m_axi_awvalid = (state == ST_AW) && (outstanding < OST_W'(MAX_OUTSTANDING));
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awlen   = 8'(burst_len - 9'd1);
    assign bus.m_axi_awid    = '0;
    assign bus.m_axi_awsize  = 3'(BPB_LOG);
    assign bus.m_axi_awburst = AXI_BURST_INCR;
    assign bus.m_axi_awlock  = 1'b0;
    assign bus.m_axi_awcache = AXI_CACHE_BUF;
    assign bus.m_axi_awprot  = AXI_PROT_DATA;

    assign bus.m_axi_wvalid  = (state == ST_W) && bus.s_axis_tvalid;
    assign bus.s_axis_tready = (state == ST_W) && bus.m_axi_wready;
    assign bus.m_axi_wdata   = bus.s_axis_tdata;
    assign bus.m_axi_wstrb   = bus.s_axis_tkeep;
    assign bus.m_axi_wlast   = (state == ST_W) && (beat_cnt == burst_q - 9'd1);
    assign bus.m_axi_bready  = 1'b1;

    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = (state == ST_DONE);
    assign bus.err_resp = err_resp_q;
    assign bus.err_len  = err_len_q;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            beats_left <= '0;
            burst_q    <= '0;
            beat_cnt   <= '0;
            err_resp_q <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.cmd_valid) begin
                    addr_q     <= bus.cmd_addr & ~ADDR_WIDTH'(KEEP_WIDTH - 1);
                    beats_left <= cmd_beats;
                    err_resp_q <= 1'b0;
                    err_len_q  <= 1'b0;
                    state      <= (cmd_beats == 32'd0) ? ST_DONE : ST_AW;
                end
                ST_AW: if (aw_hs) begin
                    addr_q     <= addr_q + (ADDR_WIDTH'(burst_len) << BPB_LOG);
                    beats_left <= beats_left - 32'(burst_len);
                    burst_q    <= burst_len;
                    beat_cnt   <= '0;
                    state      <= ST_W;
                end
                ST_W: if (w_hs) begin
                    beat_cnt <= beat_cnt + 9'd1;
                    if (bus.s_axis_tlast != last_of_cmd)
                        err_len_q <= 1'b1;
                    if (bus.m_axi_wlast)
                        state <= (beats_left != 32'd0) ? ST_AW : ST_WAIT_B;
                end
                ST_WAIT_B: if (outstanding == '0) state <= ST_DONE;
                ST_DONE:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
            if (b_hs && (bus.m_axi_bresp != AXI_RESP_OKAY))
                err_resp_q <= 1'b1;
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn)
            outstanding <= '0;
        else if (aw_hs && !b_hs)
            outstanding <= outstanding + 1'b1;
        else if (b_hs && !aw_hs)
            outstanding <= outstanding - 1'b1;
    end
endmodule

// File: doc/capture_wr_sched.md
CAPTURE_WR_SCHED -- requirements
Module: capture_wr_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, AXI/AXIS data width in bits.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, strobe width; bytes per beat BPB = KEEP_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 34, AXI address width.
REQ-004 SHALL have parameter MAX_BURST_LEN, default 16, maximum beats per AXI burst (1..256).
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4, maximum AW bursts awaiting a B response.
REQ-006 SHALL have ports:
- m_axi_aclk  in  1  single clock; all logic on its rising edge.
- m_axi_aresetn  in  1  asynchronous, active-low reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_addr  in  ADDR_WIDTH  capture base address.
- cmd_len  in  32  transfer length in bytes.
- s_axis_tdata / tkeep / tvalid / tlast / tready  in/in/in/in/out  DATA_WIDTH/KEEP_WIDTH/1/1/1  FIFO-side capture stream.
- m_axi_aw*  out (awready in)  awid 6, awaddr ADDR_WIDTH, awlen 8, awsize 3, awburst 2, awlock 1, awcache 4, awprot 3, awvalid 1  write-address channel.
- m_axi_w*  out (wready in)  wdata DATA_WIDTH, wstrb KEEP_WIDTH, wlast 1, wvalid 1  write-data channel.
- m_axi_bid / bresp / bvalid / bready  in/in/in/out  6/2/1/1  write-response channel.
- busy / done / err_resp / err_len  out  1 each  status.

Function
REQ-007 SHALL accept a command (cmd_valid & cmd_ready) only in IDLE; cmd_ready = 1 in IDLE, else 0.
REQ-008 SHALL force the low log2(BPB) bits of cmd_addr to zero and compute total beats = ceil(cmd_len/BPB) in 32-bit unsigned arithmetic.
REQ-009 SHALL use the FSM states IDLE, AW, W, WAIT_B, DONE.
- IDLE -> AW on command accept with beats > 0.
- IDLE -> DONE on command accept with beats = 0.
- AW -> W on the AW handshake.
- W -> AW on the wlast handshake when beats remain.
- W -> WAIT_B on the wlast handshake when no beats remain.
- WAIT_B -> DONE when outstanding = 0.
- DONE -> IDLE after one cycle.
REQ-010 SHALL set each burst length = min(remaining beats, MAX_BURST_LEN, beats to the next 4 KiB boundary); awlen = length-1.
REQ-011 SHALL drive awvalid only in AW state and only while outstanding < MAX_OUTSTANDING; awaddr, awlen SHALL be stable while awvalid is high and awready is low.
REQ-012 SHALL drive constant AW fields:
- awid = 0, awsize = log2(BPB), awburst = 2'b01, awlock = 0, awcache = 4'b0011, awprot = 3'b000.
REQ-013 SHALL pass the stream through combinationally in W state:
- wvalid = s_axis_tvalid; s_axis_tready = m_axi_wready; wdata = tdata; wstrb = tkeep.
- In all other states, s_axis_tready = 0 and wvalid = 0.
REQ-014 SHALL assert wlast on the final beat of each burst, generated from a beat counter and independent of tlast.
REQ-015 SHALL set sticky err_len when tlast arrives on any beat other than the last beat of the command, or when tlast is absent on that last beat; the beat is still written.
REQ-016 SHALL update the outstanding counter:
- +1 on the AW handshake, -1 on the B handshake, unchanged on both in the same cycle.
- bready held at 1.
REQ-017 SHALL set sticky err_resp when a B handshake carries bresp != 2'b00.
REQ-018 SHALL pulse done for exactly one cycle in DONE state; err_resp and err_len SHALL clear on the next command accept.
REQ-019 SHALL assert busy in every state except IDLE.
REQ-020 SHALL advance the address by length*BPB after each AW handshake, with ADDR_WIDTH wrap and no error.

Reset
REQ-021 SHALL on m_axi_aresetn low immediately:
- enter IDLE and zero all counters;
- drive awvalid = wvalid = done = busy = err_resp = err_len = 0, bready = 1, cmd_ready = 1.
REQ-022 SHALL discard all outstanding bursts on reset mid-operation, with no completion signalled; any B responses arriving after reset SHALL be consumed and ignored.

Structure
REQ-023 SHALL place the FSM state encoding, AXI burst/resp constants and the 4 KiB boundary constant in shared package capture_pkg.
REQ-024 SHALL implement the burst-length computation (REQ-010) as sub-module capture_burst_calc.

Verification (DATA_WIDTH=512, BPB=64, MAX_BURST_LEN=16)
REQ-025 SHALL cover: addr 0x0, len 1024 -> one AW, awaddr 0x0, awlen 15; 16 W beats, wlast on beat 16; done after B, errors 0.
REQ-026 SHALL cover: addr 0xF80, len 512 -> AW 0xF80 awlen 1, then AW 0x1000 awlen 5; done, errors 0.
REQ-027 SHALL cover: len 0 -> done one cycle after accept; no AW, W or B activity.
REQ-028 SHALL cover: MAX_OUTSTANDING=2, len 4096, bvalid withheld -> exactly 2 AW handshakes; third awvalid held low until the first B.
REQ-029 SHALL cover: bresp = 2'b10 on the 2nd of 3 bursts -> all bursts complete, done pulses with err_resp = 1; tlast on beat 5 of 16 -> err_len = 1.
REQ-030 SHALL cover: aresetn low mid-W -> awvalid = wvalid = busy = 0 immediately; next command completes normally.
